// File: rtl/huff_pkg.sv
// Shared types and sizes for the Huffman frequency sorter.
package huff_pkg;

   localparam int N_SYM = 10;
   localparam int CNT_W = 8;
   localparam int SYM_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SORT,
      EMIT,
      DONE
   } state_t;

   typedef struct packed {
      logic [SYM_W-1:0] sym;
      logic [CNT_W-1:0] cnt;
   } pair_t;

   // Number of symbols whose count slice on the packed bus is nonzero.
   function automatic logic [SYM_W-1:0] count_nonzero(input logic [N_SYM*CNT_W-1:0] bus);
      logic [SYM_W-1:0] n;
      n = '0;
      for (int k = 0; k < N_SYM; k++) begin
         if (bus[k*CNT_W +: CNT_W] != '0) begin
            n = n + SYM_W'(1);
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/huff_cmp_swap.sv
// Combinational compare-exchange cell: orders two pairs by count, then by symbol.
module huff_cmp_swap
   import huff_pkg::*;
(
   input  pair_t a,
   input  pair_t b,
   output pair_t lo,
   output pair_t hi
);

   logic swap;

   // Equal counts fall back to symbol order so the final sequence is deterministic.
   always_comb begin
      swap = (a.cnt > b.cnt) || ((a.cnt == b.cnt) && (a.sym > b.sym));
      lo   = swap ? b : a;
      hi   = swap ? a : b;
   end

endmodule

// File: rtl/huff_freq_sort.sv
// Captures ten symbol counts, sorts them by odd-even transposition and
// streams the nonzero (symbol, count) pairs lowest-count first.
module huff_freq_sort
   import huff_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [N_SYM*CNT_W-1:0] Count_bus,
   input  logic                   Out_ready,
   output logic                   Out_valid,
   output logic [SYM_W-1:0]       Sym_out,
   output logic [CNT_W-1:0]       Freq_out,
   output logic [SYM_W-1:0]       Nz_cnt,
   output logic                   Done,
   output logic                   Busy
);

   localparam logic [SYM_W-1:0] LAST  = SYM_W'(N_SYM - 1);
   localparam int               N_EVN = N_SYM / 2;
   localparam int               N_ODD = (N_SYM - 1) / 2;

   state_t           state;
   state_t           next_state;
   pair_t            arr    [N_SYM];
   pair_t            sorted [N_SYM];
   pair_t            cell_a [N_EVN];
   pair_t            cell_b [N_EVN];
   pair_t            cell_lo[N_EVN];
   pair_t            cell_hi[N_EVN];
   pair_t            cur;
   logic [SYM_W-1:0] phase;
   logic [SYM_W-1:0] ptr;
   logic [SYM_W-1:0] nz_cnt;
   logic             capture;
   logic             sort_step;
   logic             advance;
   logic             valid_c;
   logic             done_c;
   logic             busy_c;

   // One bank of compare-exchange cells, inputs steered by phase parity.
   for (genvar j = 0; j < N_EVN; j++) begin : g_cell
      localparam int EA = 2 * j;
      localparam int OA = (j < N_ODD) ? (2 * j + 1) : (2 * j);
      assign cell_a[j] = phase[0] ? arr[OA]     : arr[EA];
      assign cell_b[j] = phase[0] ? arr[OA + 1] : arr[EA + 1];
      huff_cmp_swap u_cmp (
         .a  (cell_a[j]),
         .b  (cell_b[j]),
         .lo (cell_lo[j]),
         .hi (cell_hi[j])
      );
   end

   // Write the cell results back to the slots they came from for this phase.
   always_comb begin
      sorted = arr;
      if (!phase[0]) begin
         for (int j = 0; j < N_EVN; j++) begin
            sorted[2*j]     = cell_lo[j];
            sorted[2*j + 1] = cell_hi[j];
         end
      end else begin
         for (int j = 0; j < N_ODD; j++) begin
            sorted[2*j + 1] = cell_lo[j];
            sorted[2*j + 2] = cell_hi[j];
         end
      end
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      sort_step  = 1'b0;
      advance    = 1'b0;
      valid_c    = 1'b0;
      done_c     = 1'b0;
      busy_c     = 1'b0;
      cur        = arr[ptr];
      case (state)
         IDLE: begin
            if (Start) begin
               capture    = 1'b1;
               next_state = SORT;
            end
         end
         SORT: begin
            busy_c    = 1'b1;
            sort_step = 1'b1;
            if (phase == LAST) begin
               next_state = EMIT;
            end
         end
         EMIT: begin
            busy_c  = 1'b1;
            valid_c = (cur.cnt != '0);
            advance = !valid_c || Out_ready;
            if (advance && (ptr == LAST)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            done_c = 1'b1;
            if (Start) begin
               capture    = 1'b1;
               next_state = SORT;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Pair array, phase counter, emit pointer and nonzero count.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int k = 0; k < N_SYM; k++) begin
            arr[k] <= '{sym: SYM_W'(k), cnt: '0};
         end
         phase  <= '0;
         ptr    <= '0;
         nz_cnt <= '0;
      end else if (capture) begin
         for (int k = 0; k < N_SYM; k++) begin
            arr[k] <= '{sym: SYM_W'(k), cnt: Count_bus[k*CNT_W +: CNT_W]};
         end
         phase  <= '0;
         ptr    <= '0;
         nz_cnt <= count_nonzero(Count_bus);
      end else if (sort_step) begin
         arr   <= sorted;
         phase <= phase + SYM_W'(1);
         ptr   <= '0;
      end else if (advance) begin
         ptr <= (ptr == LAST) ? '0 : ptr + SYM_W'(1);
      end
   end

   assign Out_valid = valid_c;
   assign Sym_out   = (state == EMIT) ? cur.sym : '0;
   assign Freq_out  = (state == EMIT) ? cur.cnt : '0;
   assign Nz_cnt    = nz_cnt;
   assign Done      = done_c;
   assign Busy      = busy_c;

endmodule

// File: tb/tb_huff_freq_sort.sv
// Randomized self-checking bench for huff_freq_sort against a sorted-list model.
module tb_huff_freq_sort;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [79:0] Count_bus;
   logic        Out_ready;
   logic        Out_valid;
   logic [3:0]  Sym_out;
   logic [7:0]  Freq_out;
   logic [3:0]  Nz_cnt;
   logic        Done;
   logic        Busy;

   int checks;
   int errors;

   int          cnt_m[10];
   logic [79:0] bus_v;
   int          exp_sym[$];
   int          exp_cnt[$];
   int          exp_nz;
   int          got_sym[$];
   int          got_cnt[$];
   int          first_valid;
   int          done_cyc;
   int          stall_err;
   int          nz_seen;
   int          timeout;

   huff_freq_sort dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Count_bus (Count_bus),
      .Out_ready (Out_ready),
      .Out_valid (Out_valid),
      .Sym_out   (Sym_out),
      .Freq_out  (Freq_out),
      .Nz_cnt    (Nz_cnt),
      .Done      (Done),
      .Busy      (Busy)
   );

   // 10 ns clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Reference: nonzero pairs listed by ascending count, ties by ascending symbol.
   task automatic model_build();
      exp_sym.delete();
      exp_cnt.delete();
      exp_nz = 0;
      for (int s = 0; s < 10; s++) begin
         if (cnt_m[s] != 0) exp_nz++;
         bus_v[s*8 +: 8] = cnt_m[s][7:0];
      end
      for (int v = 1; v < 256; v++) begin
         for (int s = 0; s < 10; s++) begin
            if (cnt_m[s] == v) begin
               exp_sym.push_back(s);
               exp_cnt.push_back(v);
            end
         end
      end
   endtask

   task automatic load_case1();
      cnt_m = '{5, 3, 9, 1, 0, 0, 7, 2, 0, 4};
      model_build();
   endtask

   // Pulse Start with bus_v and record accepted pairs until Done (bounded).
   // ready_mode: 0 always ready, 1 ready every third valid cycle, 2 random.
   task automatic run_capture(input int ready_mode, input bit hold_start);
      int k;
      bit stalled;
      int psym;
      int pfreq;
      got_sym.delete();
      got_cnt.delete();
      first_valid = -1;
      done_cyc    = -1;
      stall_err   = 0;
      timeout     = 0;
      nz_seen     = -1;
      k           = 0;
      stalled     = 1'b0;
      psym        = 0;
      pfreq       = 0;
      @(negedge Clk);
      Count_bus = bus_v;
      Start     = 1'b1;
      Out_ready = 1'b1;
      @(negedge Clk);
      if (!hold_start) Start = 1'b0;
      for (int n = 1; n <= 400; n++) begin
         if (n == 1) nz_seen = int'(Nz_cnt);
         if (stalled && !(Out_valid && int'(Sym_out) == psym && int'(Freq_out) == pfreq)) stall_err++;
         if (Done) begin
            done_cyc = n;
            break;
         end
         if (Out_valid) begin
            if (first_valid < 0) first_valid = n;
            case (ready_mode)
               0:       Out_ready = 1'b1;
               1:       Out_ready = (k % 3 == 2);
               default: Out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            if (Out_ready) begin
               got_sym.push_back(int'(Sym_out));
               got_cnt.push_back(int'(Freq_out));
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               psym    = int'(Sym_out);
               pfreq   = int'(Freq_out);
            end
         end else begin
            Out_ready = 1'b1;
            stalled   = 1'b0;
         end
         @(negedge Clk);
      end
      if (done_cyc < 0) timeout = 1;
   endtask

   task automatic test_reset();
      Reset     = 1'b0;
      Start     = 1'b0;
      Out_ready = 1'b1;
      Count_bus = '0;
      repeat (2) @(negedge Clk);
      checks++; if (Out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", Out_valid); end
      checks++; if (Sym_out !== 4'd0) begin errors++; $display("[TB] FAIL reset_sym got %0d want 0", Sym_out); end
      checks++; if (Freq_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_freq got %0d want 0", Freq_out); end
      checks++; if (Nz_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_nz got %0d want 0", Nz_cnt); end
      checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", Done); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("[TB] FAIL idle_flags got busy=%b done=%b want 0/0", Busy, Done); end
   endtask

   task automatic test_basic();
      load_case1();
      run_capture(0, 1'b0);
      checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL basic_timeout got no Done want Done"); end
      checks++; if (nz_seen != exp_nz) begin errors++; $display("[TB] FAIL basic_nz got %0d want %0d", nz_seen, exp_nz); end
      checks++; if (first_valid != 14) begin errors++; $display("[TB] FAIL basic_latency got %0d want 14", first_valid); end
      checks++; if (done_cyc != 21) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d want 21", done_cyc); end
      checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", got_sym.size(), exp_sym.size()); end
      for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
         checks++;
         if (got_sym[i] != exp_sym[i] || got_cnt[i] != exp_cnt[i]) begin
            errors++; $display("[TB] FAIL basic_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_sym[i], got_cnt[i], exp_sym[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_ties();
      for (int s = 0; s < 9; s++) cnt_m[s] = 25;
      cnt_m[9] = 30;
      model_build();
      run_capture(0, 1'b0);
      checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL ties_timeout got no Done want Done"); end
      checks++; if (nz_seen != 10) begin errors++; $display("[TB] FAIL ties_nz got %0d want 10", nz_seen); end
      checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("[TB] FAIL ties_count got %0d want %0d", got_sym.size(), exp_sym.size()); end
      for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
         checks++;
         if (got_sym[i] != exp_sym[i] || got_cnt[i] != exp_cnt[i]) begin
            errors++; $display("[TB] FAIL ties_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_sym[i], got_cnt[i], exp_sym[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      load_case1();
      run_capture(1, 1'b0);
      checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL bp_timeout got no Done want Done"); end
      checks++; if (stall_err != 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes want 0", stall_err); end
      checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("[TB] FAIL bp_count got %0d want %0d", got_sym.size(), exp_sym.size()); end
      for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
         checks++;
         if (got_sym[i] != exp_sym[i] || got_cnt[i] != exp_cnt[i]) begin
            errors++; $display("[TB] FAIL bp_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_sym[i], got_cnt[i], exp_sym[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_all_zero();
      cnt_m = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      model_build();
      run_capture(0, 1'b0);
      checks++; if (first_valid != -1) begin errors++; $display("[TB] FAIL zero_valid got valid at %0d want never", first_valid); end
      checks++; if (nz_seen != 0) begin errors++; $display("[TB] FAIL zero_nz got %0d want 0", nz_seen); end
      checks++; if (done_cyc != 21) begin errors++; $display("[TB] FAIL zero_done_cycle got %0d want 21", done_cyc); end
   endtask

   task automatic test_reset_abort();
      bit any_out;
      load_case1();
      @(negedge Clk);
      Count_bus = bus_v;
      Start     = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (4) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      checks++; if (Busy !== 1'b0 || Out_valid !== 1'b0 || Done !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags got busy=%b valid=%b done=%b want 0/0/0", Busy, Out_valid, Done); end
      checks++; if (Nz_cnt !== 4'd0) begin errors++; $display("[TB] FAIL abort_nz got %0d want 0", Nz_cnt); end
      Reset   = 1'b1;
      any_out = 1'b0;
      for (int n = 0; n < 15; n++) begin
         @(negedge Clk);
         if (Out_valid || Busy) any_out = 1'b1;
      end
      checks++; if (any_out) begin errors++; $display("[TB] FAIL abort_quiet got activity want none"); end
      cnt_m = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      model_build();
      run_capture(0, 1'b0);
      checks++; if (nz_seen != 2) begin errors++; $display("[TB] FAIL abort_new_nz got %0d want 2", nz_seen); end
      checks++; if (got_sym.size() != 2) begin errors++; $display("[TB] FAIL abort_new_count got %0d want 2", got_sym.size()); end
      for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
         checks++;
         if (got_sym[i] != exp_sym[i] || got_cnt[i] != exp_cnt[i]) begin
            errors++; $display("[TB] FAIL abort_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_sym[i], got_cnt[i], exp_sym[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_start_held();
      bit finished;
      load_case1();
      run_capture(0, 1'b1);
      checks++; if (done_cyc != 21) begin errors++; $display("[TB] FAIL held_done_cycle got %0d want 21", done_cyc); end
      checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("[TB] FAIL held_count got %0d want %0d", got_sym.size(), exp_sym.size()); end
      @(negedge Clk);
      checks++; if (Done !== 1'b0 || Busy !== 1'b1) begin errors++; $display("[TB] FAIL held_restart got done=%b busy=%b want 0/1", Done, Busy); end
      Start    = 1'b0;
      finished = 1'b0;
      for (int n = 0; n < 60 && !finished; n++) begin
         @(negedge Clk);
         if (Done) finished = 1'b1;
      end
      checks++; if (!finished) begin errors++; $display("[TB] FAIL held_second_done got no Done want Done"); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int s = 0; s < 10; s++) begin
            if ($urandom_range(0, 3) == 0) cnt_m[s] = 0;
            else if (it % 2 == 0) cnt_m[s] = int'($urandom_range(1, 4));
            else cnt_m[s] = int'($urandom_range(1, 255));
         end
         model_build();
         run_capture(2, 1'b0);
         checks++; if (timeout != 0) begin errors++; $display("[TB] FAIL rand%0d_timeout got no Done want Done", it); end
         checks++; if (nz_seen != exp_nz) begin errors++; $display("[TB] FAIL rand%0d_nz got %0d want %0d", it, nz_seen, exp_nz); end
         checks++; if (stall_err != 0) begin errors++; $display("[TB] FAIL rand%0d_stable got %0d changes want 0", it, stall_err); end
         checks++; if (got_sym.size() != exp_sym.size()) begin errors++; $display("[TB] FAIL rand%0d_count got %0d want %0d", it, got_sym.size(), exp_sym.size()); end
         for (int i = 0; i < exp_sym.size() && i < got_sym.size(); i++) begin
            checks++;
            if (got_sym[i] != exp_sym[i] || got_cnt[i] != exp_cnt[i]) begin
               errors++; $display("[TB] FAIL rand%0d_pair%0d got (%0d,%0d) want (%0d,%0d)", it, i, got_sym[i], got_cnt[i], exp_sym[i], exp_cnt[i]);
            end
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      checks = 0;
      errors = 0;
      bus_v  = '0;
      test_reset();
      test_basic();
      test_ties();
      test_backpressure();
      test_all_zero();
      test_reset_abort();
      test_start_held();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
